// File: rtl/vector_dac_pkg.sv
// rtl/vector_dac_pkg.sv - shared types, constants and frame builder for vector_dac_stream
//
// Purpose: state encoding for the transfer FSM, DAC frame layout constants and
//          a helper that assembles one 16-bit MCP4922-style command word.
// Contents: dac_state_e, FRAME_W, DATA_FIELD_W, *_BIT positions, build_frame().
package vector_dac_pkg;

   localparam int FRAME_W      = 16;
   localparam int DATA_FIELD_W = 12;

   localparam int AB_BIT     = 15;
   localparam int BUF_BIT    = 14;
   localparam int GA_N_BIT   = 13;
   localparam int SHDN_N_BIT = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_A,
      ST_GAP_A,
      ST_SHIFT_B,
      ST_GAP_B,
      ST_LATCH
   } dac_state_e;

   // data must already be left-aligned into the 12-bit field
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic                    ab,
      input logic                    cfg_buf,
      input logic                    cfg_ga_n,
      input logic [DATA_FIELD_W-1:0] data
   );
      logic [FRAME_W-1:0] f;
      f                    = '0;
      f[DATA_FIELD_W-1:0]  = data;
      f[SHDN_N_BIT]        = 1'b1;
      f[GA_N_BIT]          = cfg_ga_n;
      f[BUF_BIT]           = cfg_buf;
      f[AB_BIT]            = ab;
      return f;
   endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// rtl/dac_frame_shifter.sv - one lane's 16-bit MSB-first serial shift register
//
// Purpose: holds the frame being serialised on one DAC data line; shifts left
//          with zero fill so the line idles low once all 16 bits are out.
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high reset
//   load       - load load_frame (wins over shift)
//   shift      - advance to the next bit
//   load_frame - frame to load
//   sdat       - current serial bit (registered MSB)
module dac_frame_shifter
   import vector_dac_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-1:0] load_frame,
   output logic               sdat
);

   logic [FRAME_W-1:0] sr_q;
   logic [FRAME_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = load_frame;
      end else if (shift) begin
         sr_d = {sr_q[FRAME_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sdat = sr_q[FRAME_W-1];

endmodule

// File: rtl/vector_dac_stream.sv
// rtl/vector_dac_stream.sv - multi-lane SPI driver for dual 12-bit DACs (vector beam X/Y/colour)
//
// Purpose: accepts one beam sample per valid/ready handshake, applies per-channel
//          inversion, serialises channel A then channel B to every DAC chip on
//          parallel lanes sharing SCLK/CS, then pulses LDAC and updates blank.
// Optional: define VECTOR_DAC_SKIP_UNCHANGED_EN to suppress retransmission of a
//           sample identical to the last transmitted one (blank still updates).
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   sample_valid/ready    - sample handshake (ready only while idle)
//   sample_data           - lane L ch A at [(2L)*DAC_W], ch B at [(2L+1)*DAC_W]
//   sample_blank_n        - beam on for this sample
//   invert                - per-channel inversion, same order as sample_data
//   dac_sclk/cs_n/lat_n   - shared SPI clock, chip select, LDAC
//   dac_sdat              - per-lane serial data, MSB first
//   blank_out_n           - blank, updated when the DACs latch
//   busy                  - transfer in progress
//   frame_count           - completed latches, wrapping
module vector_dac_stream
   import vector_dac_pkg::*;
#(
   parameter int   NUM_LANES = 3,
   parameter int   DAC_W     = 12,
   parameter int   CLK_DIV   = 4,
   parameter logic CFG_BUF   = 1'b0,
   parameter logic CFG_GA_N  = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         sample_valid,
   output logic                         sample_ready,
   input  logic [2*NUM_LANES*DAC_W-1:0] sample_data,
   input  logic                         sample_blank_n,
   input  logic [2*NUM_LANES-1:0]       invert,
   output logic                         dac_sclk,
   output logic                         dac_cs_n,
   output logic                         dac_lat_n,
   output logic [NUM_LANES-1:0]         dac_sdat,
   output logic                         blank_out_n,
   output logic                         busy,
   output logic [15:0]                  frame_count
);

   localparam int NUM_CH   = 2 * NUM_LANES;
   localparam int SAMPLE_W = NUM_CH * DAC_W;
   localparam int LANE_W   = NUM_LANES * DAC_W;
   localparam int CNT_W    = $clog2(2 * CLK_DIV);

   localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLK_DIV - 1);

   dac_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [3:0]         bit_q;
   logic               ready_q;
   logic               busy_q;
   logic               sclk_q;
   logic               cs_n_q;
   logic               lat_n_q;
   logic               blank_q;
   logic               blank_out_q;
   logic [15:0]        frame_count_q;
   logic [LANE_W-1:0]  data_b_q;

   logic [SAMPLE_W-1:0] inv_data;
   logic [LANE_W-1:0]   inv_b;
   logic                accept;
   logic                skip;
   logic                start;
   logic                load_a;
   logic                load_b;
   logic                shift_stb;
   logic                latch_done;

   always_comb begin
      inv_data = '0;
      inv_b    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         inv_data[c*DAC_W +: DAC_W] = sample_data[c*DAC_W +: DAC_W] ^ {DAC_W{invert[c]}};
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         inv_b[l*DAC_W +: DAC_W] = inv_data[(2*l+1)*DAC_W +: DAC_W];
      end
   end

   assign accept     = sample_valid & ready_q;
   assign start      = accept & ~skip;
   assign latch_done = (state_q == ST_LATCH) && (cnt_q == GAP_LAST);

`ifdef VECTOR_DAC_SKIP_UNCHANGED_EN
   logic [SAMPLE_W-1:0] pend_q;
   logic [SAMPLE_W-1:0] last_q;
   logic                sent_q;

   assign skip = sent_q && (inv_data == last_q);

   // last_q only commits once the frame actually latched, so an aborted
   // transfer never counts as "already shown"
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q <= '0;
         last_q <= '0;
         sent_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start) begin
            pend_q <= inv_data;
         end
         if (latch_done) begin
            last_q <= pend_q;
            sent_q <= 1'b1;
         end
      end
   end
`else
   assign skip = 1'b0;
`endif

   // Frame A loads straight from the live input on the accept edge so its MSB
   // is on the line in the first SHIFT_A cycle; frame B loads from the capture.
   assign load_a    = (state_q == ST_IDLE) && start;
   assign load_b    = (state_q == ST_GAP_A) && (cnt_q == GAP_LAST);
   assign shift_stb = ((state_q == ST_SHIFT_A) || (state_q == ST_SHIFT_B)) && (cnt_q == BIT_LAST);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [DATA_FIELD_W-1:0] a_al;
      logic [DATA_FIELD_W-1:0] b_al;
      logic [FRAME_W-1:0]      frame;

      assign a_al  = DATA_FIELD_W'(inv_data[(2*l)*DAC_W +: DAC_W]) << (DATA_FIELD_W - DAC_W);
      assign b_al  = DATA_FIELD_W'(data_b_q[l*DAC_W +: DAC_W]) << (DATA_FIELD_W - DAC_W);
      assign frame = (state_q == ST_IDLE) ? build_frame(1'b0, CFG_BUF, CFG_GA_N, a_al)
                                          : build_frame(1'b1, CFG_BUF, CFG_GA_N, b_al);

      dac_frame_shifter u_shifter (
         .clock      (clock),
         .reset      (reset),
         .load       (load_a | load_b),
         .shift      (shift_stb),
         .load_frame (frame),
         .sdat       (dac_sdat[l])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bit_q         <= '0;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
         sclk_q        <= 1'b0;
         cs_n_q        <= 1'b1;
         lat_n_q       <= 1'b1;
         blank_q       <= 1'b0;
         blank_out_q   <= 1'b0;
         frame_count_q <= '0;
         data_b_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (skip) begin
                     blank_out_q <= sample_blank_n;
                  end else begin
                     state_q  <= ST_SHIFT_A;
                     blank_q  <= sample_blank_n;
                     data_b_q <= inv_b;
                     ready_q  <= 1'b0;
                     busy_q   <= 1'b1;
                     cs_n_q   <= 1'b0;
                     cnt_q    <= '0;
                     bit_q    <= '0;
                  end
               end
            end
            ST_SHIFT_A, ST_SHIFT_B: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q  <= '0;
                  sclk_q <= 1'b0;
                  if (bit_q == 4'd15) begin
                     bit_q   <= '0;
                     cs_n_q  <= 1'b1;
                     state_q <= (state_q == ST_SHIFT_A) ? ST_GAP_A : ST_GAP_B;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  // second half of each bit period drives SCLK high
                  cnt_q  <= cnt_q + 1'b1;
                  sclk_q <= ((cnt_q + 1'b1) >= HALF);
               end
            end
            ST_GAP_A, ST_GAP_B: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (state_q == ST_GAP_A) begin
                     state_q <= ST_SHIFT_B;
                     cs_n_q  <= 1'b0;
                  end else begin
                     state_q <= ST_LATCH;
                     lat_n_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_LATCH: begin
               if (latch_done) begin
                  state_q       <= ST_IDLE;
                  cnt_q         <= '0;
                  lat_n_q       <= 1'b1;
                  blank_out_q   <= blank_q;
                  frame_count_q <= frame_count_q + 16'd1;
                  ready_q       <= 1'b1;
                  busy_q        <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sample_ready = ready_q;
   assign busy         = busy_q;
   assign dac_sclk     = sclk_q;
   assign dac_cs_n     = cs_n_q;
   assign dac_lat_n    = lat_n_q;
   assign blank_out_n  = blank_out_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vector_dac_stream.sv
// tb/tb_vector_dac_stream.sv - self-checking bench for vector_dac_stream
module tb_vector_dac_stream;

   localparam int   NL     = 3;
   localparam int   DW     = 12;
   localparam int   CD     = 4;
   localparam int   CH     = 2 * NL;
   localparam int   SW     = CH * DW;
   localparam logic TB_BUF = 1'b0;
   localparam logic TB_GAN = 1'b1;
   localparam int   XFER_CYCLES = 1 + 2 * (32 * CD + CD) + CD;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic [SW-1:0] sample_data = '0;
   logic          sample_blank_n = 1'b0;
   logic [CH-1:0] invert = '0;
   logic          dac_sclk;
   logic          dac_cs_n;
   logic          dac_lat_n;
   logic [NL-1:0] dac_sdat;
   logic          blank_out_n;
   logic          busy;
   logic [15:0]   frame_count;

   vector_dac_stream #(
      .NUM_LANES (NL),
      .DAC_W     (DW),
      .CLK_DIV   (CD),
      .CFG_BUF   (TB_BUF),
      .CFG_GA_N  (TB_GAN)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .sample_data    (sample_data),
      .sample_blank_n (sample_blank_n),
      .invert         (invert),
      .dac_sclk       (dac_sclk),
      .dac_cs_n       (dac_cs_n),
      .dac_lat_n      (dac_lat_n),
      .dac_sdat       (dac_sdat),
      .blank_out_n    (blank_out_n),
      .busy           (busy),
      .frame_count    (frame_count)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int exp_fc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- bus monitor (samples on the falling edge) ----------------
   int   ncyc = 0, acc_count = 0, acc_cyc = 0, rdy_cyc = 0, rdy_seen = 0;
   int   cs_falls = 0, bitcnt = 0, lat_run = 0, lat_len = 0, lat_pulses = 0;
   logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_lat_n = 1'b1, prev_ready = 1'b1;
   logic [15:0]      sh [NL];
   logic [NL*16-1:0] fq [$];

   always @(negedge clock) begin
      ncyc++;
      if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
         acc_count++;
         acc_cyc = ncyc;
      end
      if (sample_ready === 1'b1 && prev_ready === 1'b0) begin
         rdy_cyc = ncyc;
         rdy_seen++;
      end
      if (dac_cs_n === 1'b0 && prev_cs_n === 1'b1) begin
         cs_falls++;
         bitcnt = 0;
      end
      if (dac_sclk === 1'b1 && prev_sclk === 1'b0 && dac_cs_n === 1'b0) begin
         for (int l = 0; l < NL; l++) sh[l] = {sh[l][14:0], dac_sdat[l]};
         bitcnt++;
      end
      if (dac_cs_n === 1'b1 && prev_cs_n === 1'b0) begin
         if (bitcnt == 16) begin
            logic [NL*16-1:0] w;
            for (int l = 0; l < NL; l++) w[l*16 +: 16] = sh[l];
            fq.push_back(w);
         end
         bitcnt = 0;
      end
      if (dac_lat_n === 1'b0) begin
         lat_run++;
      end else if (prev_lat_n === 1'b0) begin
         lat_len = lat_run;
         lat_run = 0;
         lat_pulses++;
      end
      prev_sclk  = dac_sclk;
      prev_cs_n  = dac_cs_n;
      prev_lat_n = dac_lat_n;
      prev_ready = sample_ready;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_frame(input int ab, input logic [DW-1:0] v, input logic inv);
      int val;
      int ch;
      ch  = inv ? ((1 << DW) - 1 - int'(v)) : int'(v);
      val = ab * 32768 + int'(TB_BUF) * 16384 + int'(TB_GAN) * 8192 + 4096 + ch * (1 << (12 - DW));
      return val[15:0];
   endfunction

   function automatic logic [SW-1:0] rand_sample();
      logic [SW-1:0] d;
      for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   task automatic start_sample(input logic [SW-1:0] d, input logic [CH-1:0] inv, input logic bl);
      @(posedge clock);
      #2;
      sample_data    = d;
      invert         = inv;
      sample_blank_n = bl;
      sample_valid   = 1'b1;
   endtask

   task automatic wait_accept(input int base);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clock);
         if (acc_count > base) begin ok = 1; break; end
      end
      check("accept_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_ready(input int base);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clock);
         if (rdy_seen > base) begin ok = 1; break; end
      end
      check("ready_return", 32'(ok), 32'd1);
   endtask

   task automatic check_frames(input logic [SW-1:0] d, input logic [CH-1:0] inv, output logic [15:0] fa0);
      logic [NL*16-1:0] wa, wb;
      fa0 = '0;
      check("frame_queue", 32'(fq.size() >= 2), 32'd1);
      if (fq.size() >= 2) begin
         wa = fq.pop_front();
         wb = fq.pop_front();
         fa0 = wa[15:0];
         for (int l = 0; l < NL; l++) begin
            check($sformatf("frameA_l%0d", l), 32'(wa[l*16 +: 16]),
                  32'(model_frame(0, d[(2*l)*DW +: DW], inv[2*l])));
            check($sformatf("frameB_l%0d", l), 32'(wb[l*16 +: 16]),
                  32'(model_frame(1, d[(2*l+1)*DW +: DW], inv[2*l+1])));
         end
      end
   endtask

   // full single transfer with timing, latch and frame checks
   task automatic do_xfer(input logic [SW-1:0] d, input logic [CH-1:0] inv, input logic bl,
                          output logic [15:0] fa0);
      int a0, r0, c0, lp0;
      a0 = acc_count; r0 = rdy_seen; c0 = cs_falls; lp0 = lat_pulses;
      fq.delete();
      start_sample(d, inv, bl);
      wait_accept(a0);
      #2;
      sample_valid = 1'b0;
      sample_data  = rand_sample();
      invert       = CH'($urandom);
      wait_ready(r0);
      exp_fc++;
      @(negedge clock);
      check("ready_latency", 32'(rdy_cyc - acc_cyc), 32'(XFER_CYCLES));
      check("one_accept", 32'(acc_count - a0), 32'd1);
      check("cs_frames", 32'(cs_falls - c0), 32'd2);
      check("lat_pulses", 32'(lat_pulses - lp0), 32'd1);
      check("lat_len", 32'(lat_len), 32'(CD));
      check("blank_out", 32'(blank_out_n), 32'(bl));
      check("frame_count", 32'(frame_count), 32'(exp_fc[15:0]));
      check("busy_idle", 32'(busy), 32'd0);
      check_frames(d, inv, fa0);
   endtask

   initial begin
      logic [SW-1:0] d, d2;
      logic [CH-1:0] inv, inv2;
      logic [15:0]   fa0;
      int a0, c0, r0, lp0, first_acc;

      // ---- reset ----
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_ready", 32'(sample_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sclk", 32'(dac_sclk), 32'd0);
      check("rst_cs_n", 32'(dac_cs_n), 32'd1);
      check("rst_lat_n", 32'(dac_lat_n), 32'd1);
      check("rst_sdat", 32'(dac_sdat), 32'd0);
      check("rst_blank", 32'(blank_out_n), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;

      // ---- reset during bit 7 of the channel-B frame ----
      a0 = acc_count; c0 = cs_falls; lp0 = lat_pulses;
      start_sample(rand_sample(), '0, 1'b1);
      wait_accept(a0);
      #2 sample_valid = 1'b0;
      begin
         bit ok = 0;
         for (int i = 0; i < 2000; i++) begin
            @(posedge clock);
            if (cs_falls == c0 + 2 && bitcnt == 7) begin ok = 1; break; end
         end
         check("reach_b_bit7", 32'(ok), 32'd1);
      end
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("midrst_cs_n", 32'(dac_cs_n), 32'd1);
      check("midrst_lat_n", 32'(dac_lat_n), 32'd1);
      check("midrst_sclk", 32'(dac_sclk), 32'd0);
      check("midrst_ready", 32'(sample_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_fc", 32'(frame_count), 32'd0);
      check("midrst_no_latch", 32'(lat_pulses - lp0), 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      exp_fc = 0;

      // ---- directed sample: lane0 A=0xABC, B=0x123 ----
      d = rand_sample();
      d[0 +: DW]  = 12'hABC;
      d[DW +: DW] = 12'h123;
      do_xfer(d, '0, 1'b1, fa0);
      check("lane0_A_0x3ABC", 32'(fa0), 32'h3ABC);

      // ---- invert bit 0 ----
      d = rand_sample();
      d[0 +: DW] = 12'hABC;
      do_xfer(d, 6'b000001, 1'b1, fa0);
      check("lane0_A_inv_0x3543", 32'(fa0), 32'h3543);

      // ---- randomized samples ----
      for (int k = 0; k < 4; k++) begin
         do_xfer(rand_sample(), CH'($urandom), 1'($urandom), fa0);
      end

      // ---- back-to-back with valid held ----
      d = rand_sample(); inv = CH'($urandom);
      d2 = rand_sample(); inv2 = CH'($urandom);
      a0 = acc_count; c0 = cs_falls; lp0 = lat_pulses;
      fq.delete();
      start_sample(d, inv, 1'b1);
      wait_accept(a0);
      first_acc = acc_cyc;
      #2;
      sample_data = d2; invert = inv2; sample_blank_n = 1'b0;
      wait_accept(a0 + 1);
      #2 sample_valid = 1'b0;
      r0 = rdy_seen;
      check("b2b_gap", 32'(acc_cyc - first_acc), 32'(XFER_CYCLES));
      wait_ready(r0);
      exp_fc += 2;
      @(negedge clock);
      check("b2b_accepts", 32'(acc_count - a0), 32'd2);
      check("b2b_cs_frames", 32'(cs_falls - c0), 32'd4);
      check("b2b_latches", 32'(lat_pulses - lp0), 32'd2);
      check("b2b_fc", 32'(frame_count), 32'(exp_fc[15:0]));
      check("b2b_blank", 32'(blank_out_n), 32'd0);
      check_frames(d, inv, fa0);
      check_frames(d2, inv2, fa0);

      // ---- identical sample sent twice ----
      d = rand_sample();
      do_xfer(d, '0, 1'b1, fa0);
`ifdef VECTOR_DAC_SKIP_UNCHANGED_EN
      a0 = acc_count; c0 = cs_falls;
      start_sample(d, '0, 1'b0);
      wait_accept(a0);
      #2 sample_valid = 1'b0;
      @(negedge clock);
      check("skip_blank", 32'(blank_out_n), 32'd0);
      check("skip_ready", 32'(sample_ready), 32'd1);
      repeat (20) @(negedge clock);
      check("skip_no_cs", 32'(cs_falls - c0), 32'd0);
      check("skip_fc", 32'(frame_count), 32'(exp_fc[15:0]));
`else
      do_xfer(d, '0, 1'b0, fa0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
